// File: rtl/wu_store_pkg.sv
// Shared types and packed-entry layout helpers for the WU instruction store.
// The entry word is {icntl, op, dcntl, type[N-1..0], value[N-1..0]} with value slot 0 in the LSBs.
package wu_store_pkg;

  localparam int DEF_DEPTH          = 1024;
  localparam int DEF_OPT_PER_INST   = 3;
  localparam int DEF_OPT_TYPE_W     = 8;
  localparam int DEF_OPT_VALUE_W    = 8;
  localparam int DEF_OP_W           = 4;
  localparam int DEF_CNTL_W         = 2;
  localparam int DEF_OUT_FIFO_DEPTH = 4;
  localparam int DEF_MGR_ID_W       = 8;

  typedef enum logic [DEF_CNTL_W-1:0] {
    CNTL_SOD = 2'd0,
    CNTL_EOD = 2'd1,
    CNTL_SOM = 2'd2,
    CNTL_EOM = 2'd3
  } cntl_e;

  typedef struct packed {
    cntl_e                                               icntl;
    logic [DEF_OP_W-1:0]                                 op;
    cntl_e                                               dcntl;
    logic [DEF_OPT_PER_INST-1:0][DEF_OPT_TYPE_W-1:0]     opt_type;
    logic [DEF_OPT_PER_INST-1:0][DEF_OPT_VALUE_W-1:0]    opt_value;
  } wu_entry_t;

  function automatic int entry_w(input int cntl_w, input int op_w, input int n,
                                 input int type_w, input int value_w);
    return 2 * cntl_w + op_w + n * (type_w + value_w);
  endfunction

  function automatic int type_lsb(input int n, input int value_w);
    return n * value_w;
  endfunction

  function automatic int dcntl_lsb(input int n, input int type_w, input int value_w);
    return n * (type_w + value_w);
  endfunction

  function automatic int op_lsb(input int n, input int type_w, input int value_w,
                                input int cntl_w);
    return dcntl_lsb(n, type_w, value_w) + cntl_w;
  endfunction

  function automatic int icntl_lsb(input int n, input int type_w, input int value_w,
                                   input int cntl_w, input int op_w);
    return op_lsb(n, type_w, value_w, cntl_w) + op_w;
  endfunction

endpackage

// File: rtl/wu_store_fifo.sv
// Synchronous FIFO with fall-through read: a pushed word is visible at pop_data
// right after the push edge. A push is accepted while full only alongside a pop.
module wu_store_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0] count_d, count_q;
  logic             push_ok, pop_ok;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CNT_W'(1);
    end
    pop_data = mem[rd_ptr_q];
    count    = count_q;
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/wu_instruction_store.sv
// WU instruction store: run-time loaded instruction array read by fetch and
// delivered to decode through a credit-protected fall-through output FIFO.
module wu_instruction_store
  import wu_store_pkg::*;
#(
  parameter  int DEPTH          = DEF_DEPTH,
  parameter  int ADDR_W         = $clog2(DEPTH),
  parameter  int OPT_PER_INST   = DEF_OPT_PER_INST,
  parameter  int OPT_TYPE_W     = DEF_OPT_TYPE_W,
  parameter  int OPT_VALUE_W    = DEF_OPT_VALUE_W,
  parameter  int OP_W           = DEF_OP_W,
  parameter  int CNTL_W         = DEF_CNTL_W,
  parameter  int OUT_FIFO_DEPTH = DEF_OUT_FIFO_DEPTH,
  parameter  int MGR_ID_W       = DEF_MGR_ID_W,
  localparam int ENTRY_W        = entry_w(CNTL_W, OP_W, OPT_PER_INST, OPT_TYPE_W, OPT_VALUE_W)
) (
  input  logic                                clk,
  input  logic                                reset_poweron,
  input  logic [MGR_ID_W-1:0]                 sys__mgr__mgrId,
  input  logic                                cfg__wum__wr,
  input  logic [ADDR_W-1:0]                   cfg__wum__waddr,
  input  logic [ENTRY_W-1:0]                  cfg__wum__wdata,
  input  logic                                wuf__wum__valid,
  input  logic [ADDR_W-1:0]                   wuf__wum__addr,
  output logic                                wum__wuf__ready,
  output logic                                wum__wud__valid,
  output logic [CNTL_W-1:0]                   wum__wud__icntl,
  output logic [OP_W-1:0]                     wum__wud__op,
  output logic [CNTL_W-1:0]                   wum__wud__dcntl,
  output logic [OPT_PER_INST*OPT_TYPE_W-1:0]  wum__wud__option_type,
  output logic [OPT_PER_INST*OPT_VALUE_W-1:0] wum__wud__option_value,
  input  logic                                wud__wum__ready,
  output logic                                wum__wuf__wr_collision
);

  localparam int TYPE_LSB  = type_lsb(OPT_PER_INST, OPT_VALUE_W);
  localparam int DCNTL_LSB = dcntl_lsb(OPT_PER_INST, OPT_TYPE_W, OPT_VALUE_W);
  localparam int OP_LSB    = op_lsb(OPT_PER_INST, OPT_TYPE_W, OPT_VALUE_W, CNTL_W);
  localparam int ICNTL_LSB = icntl_lsb(OPT_PER_INST, OPT_TYPE_W, OPT_VALUE_W, CNTL_W, OP_W);
  localparam int CNT_W     = $clog2(OUT_FIFO_DEPTH + 1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] rd_data_p1_q;
  logic [ENTRY_W-1:0] head;
  logic               accept;
  logic               vld_p1_d, vld_p1_q;
  logic               coll_p1_d, coll_p1_q;
  logic               head_vld, fifo_pop, fifo_empty, fifo_full;
  logic [CNT_W-1:0]   fifo_count;

  // Credit counts both the S1 word and FIFO occupancy net of this cycle's pop,
  // so a push can never land on a full FIFO.
  always_comb begin
    head_vld        = !fifo_empty;
    fifo_pop        = head_vld && wud__wum__ready;
    wum__wuf__ready = (int'(fifo_count) - int'(fifo_pop) + int'(vld_p1_q)) < OUT_FIFO_DEPTH;
    accept          = wuf__wum__valid && wum__wuf__ready;
    vld_p1_d        = accept;
    coll_p1_d       = accept && cfg__wum__wr && (cfg__wum__waddr == wuf__wum__addr);
  end

  // Instruction array write port.
  always_ff @(posedge clk) begin
    if (cfg__wum__wr) begin
      mem[cfg__wum__waddr] <= cfg__wum__wdata;
    end
  end

  // Stage 0 -> 1: synchronous array read; old data wins on a same-address write.
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_data_p1_q <= mem[wuf__wum__addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      vld_p1_q  <= 1'b0;
      coll_p1_q <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      coll_p1_q <= coll_p1_d;
    end
  end

  // Stage 1 -> output FIFO.
  wu_store_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (OUT_FIFO_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (reset_poweron),
    .push      (vld_p1_q),
    .push_data (rd_data_p1_q),
    .pop       (fifo_pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!reset_poweron) begin
      assert (!(vld_p1_q && fifo_full && !fifo_pop))
        else $error("wu_instruction_store mgr %0d: output FIFO overflow", sys__mgr__mgrId);
    end
  end

  always_comb begin
    wum__wud__valid        = head_vld;
    wum__wud__icntl        = '0;
    wum__wud__op           = '0;
    wum__wud__dcntl        = '0;
    wum__wud__option_type  = '0;
    wum__wud__option_value = '0;
    if (head_vld) begin
      wum__wud__icntl        = head[ICNTL_LSB +: CNTL_W];
      wum__wud__op           = head[OP_LSB +: OP_W];
      wum__wud__dcntl        = head[DCNTL_LSB +: CNTL_W];
      wum__wud__option_type  = head[TYPE_LSB +: OPT_PER_INST*OPT_TYPE_W];
      wum__wud__option_value = head[0 +: OPT_PER_INST*OPT_VALUE_W];
    end
    wum__wuf__wr_collision = coll_p1_q;
  end

endmodule
